// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions: stage indices, controller FSM states
// and the stall/flush patterns driven onto the pipeline registers.
package cpu_pipe_pkg;

    // Pipeline register indices (bit positions in the stall/flush vectors).
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EXE = 3;
    localparam int STG_WB  = 4;

    localparam int NUM_STG = 5;

    typedef enum logic {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } pctl_state_t;

    // One stall/flush pair. Bit k applies to pipeline register k.
    typedef struct packed {
        logic [NUM_STG-1:0] stall;
        logic [NUM_STG-1:0] flush;
    } pat_t;

    // Each stalling stage freezes itself and everything upstream, and
    // injects a bubble into the register immediately downstream.
    localparam pat_t PAT_NONE     = '{stall: 5'b00000, flush: 5'b00000};
    localparam pat_t PAT_MEM      = '{stall: 5'b01111, flush: 5'b10000};
    localparam pat_t PAT_EXE      = '{stall: 5'b00111, flush: 5'b01000};
    localparam pat_t PAT_ID       = '{stall: 5'b00011, flush: 5'b00100};
    localparam pat_t PAT_IF       = '{stall: 5'b00001, flush: 5'b00010};
    // Exception redirect: squash everything younger than MEM/WB, PC moves.
    localparam pat_t PAT_EXC      = '{stall: 5'b00000, flush: 5'b11110};
    // Exception waiting on an in-flight fetch: same squash, PC held.
    localparam pat_t PAT_EXC_HOLD = '{stall: 5'b00001, flush: 5'b11110};
    // Reset: every register loads a bubble.
    localparam pat_t PAT_RESET    = '{stall: 5'b00000, flush: 5'b11111};

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register; the clear is folded into count_d so reset is synchronous.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush arbiter for the 5-stage pipeline. Resolves hazard and
// multi-cycle requests to the latest stalling stage, handles MEM-stage
// exception/ERET redirects (deferred while a fetch is in flight), and counts
// cycles in which the PC is held.
module pipeline_stall_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stcl_lw,
    input  logic              stcl_jmp,
    input  logic              if_stall,
    input  logic              div_busy,
    input  logic              mem_stall,
    input  logic              exc_valid,
    input  logic [31:0]       exc_target,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic [CNT_W-1:0]  stall_cycles
);

    pctl_state_t state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    pat_t        pat;
    logic        redir_v;
    logic [31:0] redir_pc;

    // Output decode and next-state logic, evaluated fresh every cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pat       = PAT_NONE;
        redir_v   = 1'b0;
        redir_pc  = '0;

        if (!rst_n) begin
            // Synchronous reset: bubble everything and drop any pending redirect.
            pat       = PAT_RESET;
            state_d   = RUN;
            pend_pc_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (exc_valid) begin
                        if (if_stall) begin
                            // Fetch in flight cannot be abandoned; park the target.
                            pat       = PAT_EXC_HOLD;
                            pend_pc_d = exc_target;
                            state_d   = EXC_WAIT;
                        end else begin
                            pat      = PAT_EXC;
                            redir_v  = 1'b1;
                            redir_pc = exc_target;
                        end
                    end else if (mem_stall) begin
                        pat = PAT_MEM;
                    end else if (div_busy) begin
                        pat = PAT_EXE;
                    end else if (stcl_lw || stcl_jmp) begin
                        pat = PAT_ID;
                    end else if (if_stall) begin
                        pat = PAT_IF;
                    end
                end
                EXC_WAIT: begin
                    // Further exceptions are ignored: the first one owns the redirect.
                    if (if_stall) begin
                        pat = PAT_EXC_HOLD;
                    end else begin
                        pat      = PAT_EXC;
                        redir_v  = 1'b1;
                        redir_pc = pend_pc_q;
                        state_d  = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State and pending-target registers; reset handled in the _d logic.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        state_q   <= state_d;
        pend_pc_q <= pend_pc_d;
    end

    assign stall          = STAGES'(pat.stall);
    assign flush          = STAGES'(pat.flush);
    assign redirect_valid = redir_v;
    assign redirect_pc    = redir_pc;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (~rst_n),
        .inc   (pat.stall[STG_PC]),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl (CNT_W = 4 to reach saturation).
module tb_pipeline_stall_ctrl;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stcl_lw, stcl_jmp, if_stall, div_busy, mem_stall, exc_valid;
    logic [31:0] exc_target;
    logic [4:0]  stall, flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [CW-1:0] stall_cycles;

    typedef struct {
        string       tag;
        logic        rst;
        logic [4:0]  st;
        logic [4:0]  fl;
        logic        rv;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [CW-1:0] cnt_model;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.STAGES(5), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stcl_lw        (stcl_lw),
        .stcl_jmp       (stcl_jmp),
        .if_stall       (if_stall),
        .div_busy       (div_busy),
        .mem_stall      (mem_stall),
        .exc_valid      (exc_valid),
        .exc_target     (exc_target),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cycles   (stall_cycles)
    );

    // Drive one cycle of inputs and push the outputs they must produce.
    task automatic step(input string tag, input logic rst, input logic lw, input logic jmp,
                        input logic ifs, input logic div, input logic mem, input logic exc,
                        input logic [31:0] tgt, input logic [4:0] st, input logic [4:0] fl,
                        input logic rv, input logic [31:0] pc);
        exp_t e;
        rst_n = rst; stcl_lw = lw; stcl_jmp = jmp; if_stall = ifs;
        div_busy = div; mem_stall = mem; exc_valid = exc; exc_target = tgt;
        e.tag = tag; e.rst = rst; e.st = st; e.fl = fl; e.rv = rv; e.pc = pc;
        sb.push_back(e);
        check_cycle();
    endtask

    // Pop the expectation at mid-cycle, compare, then advance the counter model at the edge.
    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty obs=0 exp=1");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (stall === e.st) else begin
            miscompares++;
            $error("FAIL %s stall obs=%b exp=%b", e.tag, stall, e.st);
        end
        vectors++;
        assert (flush === e.fl) else begin
            miscompares++;
            $error("FAIL %s flush obs=%b exp=%b", e.tag, flush, e.fl);
        end
        vectors++;
        assert (redirect_valid === e.rv) else begin
            miscompares++;
            $error("FAIL %s redirect_valid obs=%b exp=%b", e.tag, redirect_valid, e.rv);
        end
        vectors++;
        assert (redirect_pc === e.pc) else begin
            miscompares++;
            $error("FAIL %s redirect_pc obs=%h exp=%h", e.tag, redirect_pc, e.pc);
        end
        vectors++;
        assert (stall_cycles === cnt_model) else begin
            miscompares++;
            $error("FAIL %s stall_cycles obs=%0d exp=%0d", e.tag, stall_cycles, cnt_model);
        end
        @(posedge clk);
        if (!e.rst)                              cnt_model = '0;
        else if (e.st[0] && cnt_model != '1)     cnt_model = cnt_model + 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stcl_lw = 0; stcl_jmp = 0; if_stall = 0;
        div_busy = 0; mem_stall = 0; exc_valid = 0; exc_target = '0;
        @(posedge clk); #1;
        cnt_model = '0;

        //   tag          rst lw jmp if div mem exc target         stall     flush     rv pc
        step("reset",      0, 0, 0, 0, 0, 0, 0, 32'h0,          5'b00000, 5'b11111, 0, 32'h0);
        step("idle",       1, 0, 0, 0, 0, 0, 0, 32'h0,          5'b00000, 5'b00000, 0, 32'h0);
        step("load_use",   1, 1, 0, 0, 0, 0, 0, 32'h0,          5'b00011, 5'b00100, 0, 32'h0);
        step("idle2",      1, 0, 0, 0, 0, 0, 0, 32'h0,          5'b00000, 5'b00000, 0, 32'h0);
        step("jmp",        1, 0, 1, 0, 0, 0, 0, 32'h0,          5'b00011, 5'b00100, 0, 32'h0);
        step("if_only",    1, 0, 0, 1, 0, 0, 0, 32'h0,          5'b00001, 5'b00010, 0, 32'h0);
        step("div_only",   1, 0, 0, 0, 1, 0, 0, 32'h0,          5'b00111, 5'b01000, 0, 32'h0);
        step("priority",   1, 0, 1, 0, 1, 1, 0, 32'h0,          5'b01111, 5'b10000, 0, 32'h0);
        step("div_lw_if",  1, 1, 0, 1, 1, 0, 0, 32'h0,          5'b00111, 5'b01000, 0, 32'h0);
        step("exc_now",    1, 0, 0, 0, 0, 1, 1, 32'hBFC00380,   5'b00000, 5'b11110, 1, 32'hBFC00380);
        // Deferred exception: fetch busy for 3 cycles, second target ignored.
        step("exc_defer1", 1, 0, 0, 1, 0, 0, 1, 32'h80000180,   5'b00001, 5'b11110, 0, 32'h0);
        step("exc_defer2", 1, 0, 0, 1, 0, 0, 1, 32'h12345678,   5'b00001, 5'b11110, 0, 32'h0);
        step("exc_defer3", 1, 0, 0, 1, 0, 1, 0, 32'h0,          5'b00001, 5'b11110, 0, 32'h0);
        step("exc_redir",  1, 0, 0, 0, 1, 1, 0, 32'h0,          5'b00000, 5'b11110, 1, 32'h80000180);
        step("post_redir", 1, 0, 0, 0, 0, 0, 0, 32'h0,          5'b00000, 5'b00000, 0, 32'h0);
        // Reset while waiting discards the pending redirect.
        step("wait_enter", 1, 0, 0, 1, 0, 0, 1, 32'hAAAA0000,   5'b00001, 5'b11110, 0, 32'h0);
        step("wait_rst",   0, 0, 0, 1, 0, 0, 0, 32'h0,          5'b00000, 5'b11111, 0, 32'h0);
        step("after_rst",  1, 0, 0, 0, 0, 0, 0, 32'h0,          5'b00000, 5'b00000, 0, 32'h0);
        // Saturation: 20 cycles of fetch stall on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            step("sat_if",  1, 0, 0, 1, 0, 0, 0, 32'h0,          5'b00001, 5'b00010, 0, 32'h0);
        end
        step("sat_end",    1, 0, 0, 0, 0, 0, 0, 32'h0,          5'b00000, 5'b00000, 0, 32'h0);

        vectors++;
        assert (stall_cycles === 4'd15) else begin
            miscompares++;
            $error("FAIL sat_final stall_cycles obs=%0d exp=15", stall_cycles);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
